// File: rtl/pc_call_stack_pkg.sv
// Shared definitions for the sap1 program counter with return-address stack:
// default widths and the command set in priority order.
package pc_call_stack_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int STACK_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_RESET,
        CMD_RET,
        CMD_CALL,
        CMD_LOAD,
        CMD_INC
    } cmd_e;

    // Only the highest-priority asserted command acts.
    function automatic cmd_e decode_cmd(input logic reset, input logic ret,
                                        input logic call, input logic load,
                                        input logic increment);
        if (reset)          return CMD_RESET;
        else if (ret)       return CMD_RET;
        else if (call)      return CMD_CALL;
        else if (load)      return CMD_LOAD;
        else if (increment) return CMD_INC;
        else                return CMD_NONE;
    endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Controller-side bundle of the program counter: command strobes, jump target,
// PC value, stack occupancy and sticky error flags.
interface pc_call_stack_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 8
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic                  reset;
    logic                  increment;
    logic                  load;
    logic                  call;
    logic                  ret;
    logic [ADDR_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DW-1:0]         depth;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  out_of_range;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output reset, increment, load, call, ret, load_data,
        input  pc, depth, stack_full, stack_empty,
               out_of_range, stack_overflow, stack_underflow
    );

    modport slave (
        input  reset, increment, load, call, ret, load_data,
        output pc, depth, stack_full, stack_empty,
               out_of_range, stack_overflow, stack_underflow
    );

endinterface

// File: rtl/pc_call_stack_lifo_stack.sv
// Return-address LIFO; the occupancy count doubles as the push/pop pointer so
// consecutive push/pop cycles need no bubble.
module lifo_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             a_reset_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;
    logic [IW-1:0]    wr_idx, rd_idx;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign wr_idx      = IW'(count_q);
    assign rd_idx      = IW'(count_q - CW'(1));
    assign rdata_o     = mem_q[rd_idx];
    assign count_o     = count_q;

    assign do_pop      = pop_i & ~clr_i & ~empty_o;
    assign do_push     = push_i & ~pop_i & ~clr_i & ~full_o;
    assign overflow_o  = push_i & ~pop_i & ~clr_i & full_o;
    assign underflow_o = pop_i & ~clr_i & empty_o;

    always_comb begin
        count_d = count_q;
        if (clr_i)        count_d = '0;
        else if (do_pop)  count_d = count_q - CW'(1);
        else if (do_push) count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) count_q <= '0;
        else            count_q <= count_d;
    end

    // Entry storage is intentionally unreset; unoccupied slots are don't-care.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= wdata_i;
    end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter for the sap1 family with hardware CALL/RET: PC register,
// command priority decode and sticky error flags around one lifo_stack.
module pc_call_stack
    import pc_call_stack_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                    STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input logic            clk,
    input logic            a_reset_n,
    pc_call_stack_if.slave bus
);

    localparam int DW = $clog2(STACK_DEPTH + 1);

    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  oor_q, oor_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  st_clr, st_push, st_pop;
    logic [ADDR_WIDTH-1:0] st_rdata;
    logic [DW-1:0]         st_count;
    logic                  st_full, st_empty, st_overflow, st_underflow;

    assign cmd = decode_cmd(bus.reset, bus.ret, bus.call, bus.load, bus.increment);

    lifo_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .a_reset_n   (a_reset_n),
        .clr_i       (st_clr),
        .push_i      (st_push),
        .pop_i       (st_pop),
        .wdata_i     (pc_q + ADDR_WIDTH'(1)),
        .rdata_o     (st_rdata),
        .count_o     (st_count),
        .full_o      (st_full),
        .empty_o     (st_empty),
        .overflow_o  (st_overflow),
        .underflow_o (st_underflow)
    );

    always_comb begin
        pc_d    = pc_q;
        oor_d   = oor_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        st_clr  = 1'b0;
        st_push = 1'b0;
        st_pop  = 1'b0;
        unique case (cmd)
            CMD_RESET: begin
                pc_d   = RESET_ADDR;
                oor_d  = 1'b0;
                ovf_d  = 1'b0;
                unf_d  = 1'b0;
                st_clr = 1'b1;
            end
            CMD_RET: begin
                st_pop = 1'b1;
                if (!st_empty) pc_d = st_rdata;
                unf_d  = unf_q | st_underflow;
            end
            CMD_CALL: begin
                st_push = 1'b1;
                if (!st_full) pc_d = bus.load_data;
                ovf_d   = ovf_q | st_overflow;
            end
            CMD_LOAD: pc_d = bus.load_data;
            CMD_INC: begin
                // Saturate at the top of the address space rather than wrap.
                if (pc_q == '1) oor_d = 1'b1;
                else            pc_d  = pc_q + ADDR_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            pc_q  <= RESET_ADDR;
            oor_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            oor_q <= oor_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.depth           = st_count;
    assign bus.stack_full      = st_full;
    assign bus.stack_empty     = st_empty;
    assign bus.out_of_range    = oor_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;

endmodule
